// File: rtl/axi4lite_pkg.sv
// Shared constants, FSM state types and default widths for the AXI4-Lite arbiter slice.
package axi4lite_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE,
    W_XFER,
    W_RESP
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } rd_state_e;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

  function automatic logic resp_is_ok(input logic [1:0] resp);
    return (resp == RESP_OKAY) || (resp == RESP_EXOKAY);
  endfunction

endpackage

// File: rtl/axi4lite_rr_arbiter.sv
// Round-robin request picker with its own pointer; AXI4LITE_ARB_FIXED_PRIO_EN turns it
// into a fixed lowest-index-wins picker with no pointer state.
module axi4lite_rr_arbiter
  import axi4lite_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             advance,
  input  logic [IDX_W-1:0] done_idx,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] ptr;

`ifdef AXI4LITE_ARB_FIXED_PRIO_EN
  logic unused_ok;
  assign ptr       = '0;
  assign unused_ok = ^{clk, rst_n, advance, done_idx};
`else
  // Next search starts just after the master that completed, so it goes last next time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (done_idx == IDX_W'(N - 1)) ? '0 : done_idx + 1'b1;
    end
  end
`endif

  // Scan from the far end back toward ptr so the last hit is the nearest requester.
  always_comb begin
    int k;
    k       = 0;
    gnt     = '0;
    gnt_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % N;
      if (req[k]) gnt_idx = IDX_W'(k);
    end
    gnt[gnt_idx] = |req;
  end

endmodule

// File: rtl/axi4lite_arbiter.sv
// N-to-1 AXI4-Lite arbiter: independent write (AW/W/B) and read (AR/R) paths, one
// outstanding transaction each. Define AXI4LITE_ARB_FIXED_PRIO_EN for fixed priority.
module axi4lite_arbiter
  import axi4lite_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = AXI_ADDR_W,
  parameter int DATA_W      = AXI_DATA_W
) (
  input  logic                              A_CLK,
  input  logic                              A_RSTn,
  input  logic [NUM_MASTERS-1:0]            S_AW_VALID,
  output logic [NUM_MASTERS-1:0]            S_AW_READY,
  input  logic [NUM_MASTERS*ADDR_W-1:0]     S_AW_ADDR,
  input  logic [NUM_MASTERS-1:0]            S_W_VALID,
  output logic [NUM_MASTERS-1:0]            S_W_READY,
  input  logic [NUM_MASTERS*DATA_W-1:0]     S_W_DATA,
  input  logic [NUM_MASTERS*DATA_W/8-1:0]   S_W_STRB,
  output logic [NUM_MASTERS-1:0]            S_B_VALID,
  input  logic [NUM_MASTERS-1:0]            S_B_READY,
  output logic [1:0]                        S_B_RESP,
  input  logic [NUM_MASTERS-1:0]            S_AR_VALID,
  output logic [NUM_MASTERS-1:0]            S_AR_READY,
  input  logic [NUM_MASTERS*ADDR_W-1:0]     S_AR_ADDR,
  output logic [NUM_MASTERS-1:0]            S_R_VALID,
  input  logic [NUM_MASTERS-1:0]            S_R_READY,
  output logic [1:0]                        S_R_RESP,
  output logic [DATA_W-1:0]                 S_R_DATA,
  output logic                              M_AW_VALID,
  input  logic                              M_AW_READY,
  output logic [ADDR_W-1:0]                 M_AW_ADDR,
  output logic                              M_W_VALID,
  input  logic                              M_W_READY,
  output logic [DATA_W-1:0]                 M_W_DATA,
  output logic [DATA_W/8-1:0]               M_W_STRB,
  input  logic                              M_B_VALID,
  output logic                              M_B_READY,
  input  logic [1:0]                        M_B_RESP,
  output logic                              M_AR_VALID,
  input  logic                              M_AR_READY,
  output logic [ADDR_W-1:0]                 M_AR_ADDR,
  input  logic                              M_R_VALID,
  output logic                              M_R_READY,
  input  logic [1:0]                        M_R_RESP,
  input  logic [DATA_W-1:0]                 M_R_DATA
);

  localparam int IDX_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] aw_addr_a [NUM_MASTERS];
  logic [ADDR_W-1:0] ar_addr_a [NUM_MASTERS];
  logic [DATA_W-1:0] w_data_a  [NUM_MASTERS];
  logic [STRB_W-1:0] w_strb_a  [NUM_MASTERS];

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
    assign aw_addr_a[g] = S_AW_ADDR[g*ADDR_W +: ADDR_W];
    assign ar_addr_a[g] = S_AR_ADDR[g*ADDR_W +: ADDR_W];
    assign w_data_a[g]  = S_W_DATA[g*DATA_W +: DATA_W];
    assign w_strb_a[g]  = S_W_STRB[g*STRB_W +: STRB_W];
  end

  wr_state_e                w_state, w_state_nxt;
  logic [IDX_W-1:0]         wgnt, wgnt_nxt;
  logic                     aw_done, aw_done_nxt, w_done, w_done_nxt;
  logic                     w_adv;
  logic [NUM_MASTERS-1:0]   aw_gnt;
  logic [IDX_W-1:0]         aw_win;

  rd_state_e                r_state, r_state_nxt;
  logic [IDX_W-1:0]         rgnt, rgnt_nxt;
  logic                     r_adv;
  logic [NUM_MASTERS-1:0]   ar_gnt;
  logic [IDX_W-1:0]         ar_win;

  axi4lite_rr_arbiter #(.N(NUM_MASTERS), .IDX_W(IDX_W)) u_wr_arb (
    .clk      (A_CLK),
    .rst_n    (A_RSTn),
    .req      (S_AW_VALID),
    .advance  (w_adv),
    .done_idx (wgnt),
    .gnt      (aw_gnt),
    .gnt_idx  (aw_win)
  );

  axi4lite_rr_arbiter #(.N(NUM_MASTERS), .IDX_W(IDX_W)) u_rd_arb (
    .clk      (A_CLK),
    .rst_n    (A_RSTn),
    .req      (S_AR_VALID),
    .advance  (r_adv),
    .done_idx (rgnt),
    .gnt      (ar_gnt),
    .gnt_idx  (ar_win)
  );

  always_ff @(posedge A_CLK or negedge A_RSTn) begin
    if (!A_RSTn) begin
      w_state <= W_IDLE;
      wgnt    <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      r_state <= R_IDLE;
      rgnt    <= '0;
    end else begin
      w_state <= w_state_nxt;
      wgnt    <= wgnt_nxt;
      aw_done <= aw_done_nxt;
      w_done  <= w_done_nxt;
      r_state <= r_state_nxt;
      rgnt    <= rgnt_nxt;
    end
  end

  // Write path: AW and W may complete in either order; B unlocks the grant.
  always_comb begin
    w_state_nxt = w_state;
    wgnt_nxt    = wgnt;
    aw_done_nxt = aw_done;
    w_done_nxt  = w_done;
    w_adv       = 1'b0;
    M_AW_VALID  = 1'b0;
    M_AW_ADDR   = '0;
    M_W_VALID   = 1'b0;
    M_W_DATA    = '0;
    M_W_STRB    = '0;
    M_B_READY   = 1'b0;
    S_AW_READY  = '0;
    S_W_READY   = '0;
    S_B_VALID   = '0;
    S_B_RESP    = RESP_OKAY;
    unique case (w_state)
      W_IDLE: begin
        if (|aw_gnt) begin
          wgnt_nxt    = aw_win;
          w_state_nxt = W_XFER;
        end
      end
      W_XFER: begin
        M_AW_VALID       = S_AW_VALID[wgnt] & ~aw_done;
        M_AW_ADDR        = aw_addr_a[wgnt];
        S_AW_READY[wgnt] = M_AW_READY & ~aw_done;
        M_W_VALID        = S_W_VALID[wgnt] & ~w_done;
        M_W_DATA         = w_data_a[wgnt];
        M_W_STRB         = w_strb_a[wgnt];
        S_W_READY[wgnt]  = M_W_READY & ~w_done;
        aw_done_nxt      = aw_done | (S_AW_VALID[wgnt] & M_AW_READY);
        w_done_nxt       = w_done | (S_W_VALID[wgnt] & M_W_READY);
        if (aw_done_nxt && w_done_nxt) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        M_B_READY       = S_B_READY[wgnt];
        S_B_VALID[wgnt] = M_B_VALID;
        S_B_RESP        = M_B_RESP;
        if (M_B_VALID && S_B_READY[wgnt]) begin
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
          w_adv       = 1'b1;
          w_state_nxt = W_IDLE;
        end
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Read path: AR then R, grant held until the R handshake.
  always_comb begin
    r_state_nxt = r_state;
    rgnt_nxt    = rgnt;
    r_adv       = 1'b0;
    M_AR_VALID  = 1'b0;
    M_AR_ADDR   = '0;
    M_R_READY   = 1'b0;
    S_AR_READY  = '0;
    S_R_VALID   = '0;
    S_R_RESP    = RESP_OKAY;
    S_R_DATA    = '0;
    unique case (r_state)
      R_IDLE: begin
        if (|ar_gnt) begin
          rgnt_nxt    = ar_win;
          r_state_nxt = R_ADDR;
        end
      end
      R_ADDR: begin
        M_AR_VALID       = S_AR_VALID[rgnt];
        M_AR_ADDR        = ar_addr_a[rgnt];
        S_AR_READY[rgnt] = M_AR_READY;
        if (S_AR_VALID[rgnt] && M_AR_READY) r_state_nxt = R_DATA;
      end
      R_DATA: begin
        M_R_READY       = S_R_READY[rgnt];
        S_R_VALID[rgnt] = M_R_VALID;
        S_R_RESP        = M_R_RESP;
        S_R_DATA        = M_R_DATA;
        if (M_R_VALID && S_R_READY[rgnt]) begin
          r_adv       = 1'b1;
          r_state_nxt = R_IDLE;
        end
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi4lite_arbiter.sv
// Randomized bench: behavioural masters and slave around the arbiter, checked against a
// transaction-level grant/pointer model.
module tb_axi4lite_arbiter;
  localparam int N    = 3;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SW   = DW / 8;
  localparam int NCYC = 3000;
  localparam int OUTW = 5*N + 2 + 2 + DW + 5 + 2*AW + DW + SW;

  logic A_CLK = 1'b0;
  logic A_RSTn;
  logic [N-1:0]    S_AW_VALID, S_W_VALID, S_B_READY, S_AR_VALID, S_R_READY;
  logic [N-1:0]    S_AW_READY, S_W_READY, S_B_VALID, S_AR_READY, S_R_VALID;
  logic [N*AW-1:0] S_AW_ADDR, S_AR_ADDR;
  logic [N*DW-1:0] S_W_DATA;
  logic [N*SW-1:0] S_W_STRB;
  logic [1:0]      S_B_RESP, S_R_RESP;
  logic [DW-1:0]   S_R_DATA;
  logic            M_AW_VALID, M_W_VALID, M_B_READY, M_AR_VALID, M_R_READY;
  logic            M_AW_READY, M_W_READY, M_B_VALID, M_AR_READY, M_R_VALID;
  logic [AW-1:0]   M_AW_ADDR, M_AR_ADDR;
  logic [DW-1:0]   M_W_DATA, M_R_DATA;
  logic [SW-1:0]   M_W_STRB;
  logic [1:0]      M_B_RESP, M_R_RESP;

  axi4lite_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .A_CLK(A_CLK), .A_RSTn(A_RSTn),
    .S_AW_VALID(S_AW_VALID), .S_AW_READY(S_AW_READY), .S_AW_ADDR(S_AW_ADDR),
    .S_W_VALID(S_W_VALID), .S_W_READY(S_W_READY), .S_W_DATA(S_W_DATA), .S_W_STRB(S_W_STRB),
    .S_B_VALID(S_B_VALID), .S_B_READY(S_B_READY), .S_B_RESP(S_B_RESP),
    .S_AR_VALID(S_AR_VALID), .S_AR_READY(S_AR_READY), .S_AR_ADDR(S_AR_ADDR),
    .S_R_VALID(S_R_VALID), .S_R_READY(S_R_READY), .S_R_RESP(S_R_RESP), .S_R_DATA(S_R_DATA),
    .M_AW_VALID(M_AW_VALID), .M_AW_READY(M_AW_READY), .M_AW_ADDR(M_AW_ADDR),
    .M_W_VALID(M_W_VALID), .M_W_READY(M_W_READY), .M_W_DATA(M_W_DATA), .M_W_STRB(M_W_STRB),
    .M_B_VALID(M_B_VALID), .M_B_READY(M_B_READY), .M_B_RESP(M_B_RESP),
    .M_AR_VALID(M_AR_VALID), .M_AR_READY(M_AR_READY), .M_AR_ADDR(M_AR_ADDR),
    .M_R_VALID(M_R_VALID), .M_R_READY(M_R_READY), .M_R_RESP(M_R_RESP), .M_R_DATA(M_R_DATA)
  );

  always #5 A_CLK = ~A_CLK;

  logic [OUTW-1:0] all_out;
  assign all_out = {S_AW_READY, S_W_READY, S_B_VALID, S_AR_READY, S_R_VALID, S_B_RESP, S_R_RESP,
                    S_R_DATA, M_AW_VALID, M_W_VALID, M_B_READY, M_AR_VALID, M_R_READY,
                    M_AW_ADDR, M_AR_ADDR, M_W_DATA, M_W_STRB};

  // Master-side state
  logic [N-1:0]  w_act, aw_todo, w_todo, r_act, ar_todo;
  int            aw_wait [N];
  int            w_wait  [N];
  int            ar_wait [N];
  logic [AW-1:0] m_aw_addr [N];
  logic [AW-1:0] m_ar_addr [N];
  logic [DW-1:0] m_w_data  [N];
  logic [SW-1:0] m_w_strb  [N];
  // Slave-side state
  logic          s_aw_have, s_w_have, s_b_v, s_ar_have, s_r_v;
  logic [1:0]    s_b_resp, s_r_resp;
  logic [DW-1:0] s_r_data;
  int            s_b_wait, s_r_wait;
  // Reference model: which master owns each path, and where the next search begins
  logic          wbusy, rbusy, w_was_idle, r_was_idle;
  int            wptr, rptr, wexp, rexp;
  int            nwr, nrd, n_err, n_chk;
  logic          did_rst;
  logic [4*N+2:0] e_w, o_w;
  logic [2*N+1:0] e_r, o_r;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] req, input int base);
    int b;
    b = base;
`ifdef AXI4LITE_ARB_FIXED_PRIO_EN
    b = 0;
`endif
    for (int k = 0; k < N; k++) if (req[(b + k) % N]) return (b + k) % N;
    return 0;
  endfunction

  task automatic clear_model();
    w_act = '0; aw_todo = '0; w_todo = '0; r_act = '0; ar_todo = '0;
    for (int i = 0; i < N; i++) begin
      aw_wait[i] = 0; w_wait[i] = 0; ar_wait[i] = 0;
      m_aw_addr[i] = '0; m_ar_addr[i] = '0; m_w_data[i] = '0; m_w_strb[i] = '0;
    end
    s_aw_have = 0; s_w_have = 0; s_b_v = 0; s_ar_have = 0; s_r_v = 0;
    s_b_resp = 0; s_r_resp = 0; s_r_data = 0;
    s_b_wait = $urandom % 3; s_r_wait = $urandom % 3;
    wbusy = 0; rbusy = 0; wptr = 0; rptr = 0; wexp = 0; rexp = 0;
  endtask

  task automatic drive_pins(input logic rnd);
    for (int i = 0; i < N; i++) begin
      S_AW_VALID[i] = aw_todo[i] && (aw_wait[i] == 0);
      S_W_VALID[i]  = w_todo[i] && (w_wait[i] == 0);
      S_AR_VALID[i] = ar_todo[i] && (ar_wait[i] == 0);
      S_AW_ADDR[i*AW +: AW] = m_aw_addr[i];
      S_AR_ADDR[i*AW +: AW] = m_ar_addr[i];
      S_W_DATA[i*DW +: DW]  = m_w_data[i];
      S_W_STRB[i*SW +: SW]  = m_w_strb[i];
    end
    S_B_READY  = rnd ? N'($urandom) : '0;
    S_R_READY  = rnd ? N'($urandom) : '0;
    M_AW_READY = rnd && !s_aw_have && (($urandom % 2) != 0);
    M_W_READY  = rnd && !s_w_have && (($urandom % 2) != 0);
    M_AR_READY = rnd && !s_ar_have && (($urandom % 2) != 0);
    M_B_VALID  = s_b_v;
    M_B_RESP   = s_b_resp;
    M_R_VALID  = s_r_v;
    M_R_RESP   = s_r_resp;
    M_R_DATA   = s_r_data;
  endtask

  initial begin
    n_err = 0; n_chk = 0; nwr = 0; nrd = 0; did_rst = 0;
    A_RSTn = 1'b0;
    clear_model();
    for (int c = 0; c < 3; c++) begin
      @(negedge A_CLK);
      drive_pins(1'b1);
      S_AW_VALID = N'($urandom); S_AR_VALID = N'($urandom); S_W_VALID = '1;
      M_B_VALID = 1'b1; M_R_VALID = 1'b1; M_R_DATA = $urandom; M_B_RESP = 2'b11;
      #1;
      chk("reset_outputs", 256'(all_out), 256'(0));
    end
    @(negedge A_CLK);
    drive_pins(1'b0);
    A_RSTn = 1'b1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge A_CLK);
      drive_pins(1'b1);

      // Asynchronous reset while a write response is pending at the slave.
      if (!did_rst && cyc > 1500 && s_b_v) begin
        #2;
        A_RSTn = 1'b0;
        #1;
        chk("reset_async_out", 256'(all_out), 256'(0));
        did_rst = 1'b1;
        clear_model();
        drive_pins(1'b0);
        @(posedge A_CLK);
        #1;
        chk("reset_held_out", 256'(all_out), 256'(0));
        @(negedge A_CLK);
        A_RSTn = 1'b1;
        continue;
      end
      #1;

      w_was_idle = !wbusy;
      r_was_idle = !rbusy;

      // Write path pin-level expectations
      if (!wbusy) begin
        chk("w_idle", 256'({M_AW_VALID, M_W_VALID, M_B_READY, S_AW_READY, S_W_READY, S_B_VALID}), 256'(0));
      end else begin
        e_w = {S_AW_VALID[wexp] & ~s_aw_have, N'(M_AW_READY & ~s_aw_have) << wexp,
               S_W_VALID[wexp] & ~s_w_have, N'(M_W_READY & ~s_w_have) << wexp,
               (s_aw_have & s_w_have) ? S_B_READY[wexp] : 1'b0,
               (s_aw_have & s_w_have) ? (N'(M_B_VALID) << wexp) : N'(0)};
        o_w = {M_AW_VALID, S_AW_READY, M_W_VALID, S_W_READY, M_B_READY, S_B_VALID};
        chk("w_hshk", 256'(o_w), 256'(e_w));
      end
      if (M_AW_VALID && M_AW_READY) begin
        chk("aw_dup", 256'(s_aw_have), 256'(0));
        chk("aw_addr", 256'(M_AW_ADDR), 256'(m_aw_addr[wexp]));
        s_aw_have = 1'b1;
      end
      if (M_W_VALID && M_W_READY) begin
        chk("w_dup", 256'(s_w_have), 256'(0));
        chk("w_data", 256'({M_W_DATA, M_W_STRB}), 256'({m_w_data[wexp], m_w_strb[wexp]}));
        s_w_have = 1'b1;
      end
      if (M_B_VALID && M_B_READY) begin
        chk("b_resp", 256'(S_B_RESP), 256'(s_b_resp));
        s_aw_have = 0; s_w_have = 0; s_b_v = 0; s_b_wait = $urandom % 3;
        nwr++;
        wptr = (wexp + 1) % N;
        wbusy = 0;
      end

      // Read path pin-level expectations
      if (!rbusy) begin
        chk("r_idle", 256'({M_AR_VALID, M_R_READY, S_AR_READY, S_R_VALID}), 256'(0));
      end else begin
        e_r = {~s_ar_have & S_AR_VALID[rexp], s_ar_have ? S_R_READY[rexp] : 1'b0,
               s_ar_have ? N'(0) : (N'(M_AR_READY) << rexp),
               s_ar_have ? (N'(M_R_VALID) << rexp) : N'(0)};
        o_r = {M_AR_VALID, M_R_READY, S_AR_READY, S_R_VALID};
        chk("r_hshk", 256'(o_r), 256'(e_r));
      end
      if (M_AR_VALID && M_AR_READY) begin
        chk("ar_dup", 256'(s_ar_have), 256'(0));
        chk("ar_addr", 256'(M_AR_ADDR), 256'(m_ar_addr[rexp]));
        s_ar_have = 1'b1;
      end
      if (M_R_VALID && M_R_READY) begin
        chk("r_data", 256'({S_R_DATA, S_R_RESP}), 256'({s_r_data, s_r_resp}));
        s_ar_have = 0; s_r_v = 0; s_r_wait = $urandom % 3;
        nrd++;
        rptr = (rexp + 1) % N;
        rbusy = 0;
      end

      // Master bookkeeping from what each master actually saw
      for (int i = 0; i < N; i++) begin
        if (S_AW_VALID[i] && S_AW_READY[i]) aw_todo[i] = 1'b0;
        if (S_W_VALID[i] && S_W_READY[i])   w_todo[i]  = 1'b0;
        if (S_B_VALID[i] && S_B_READY[i])   w_act[i]   = 1'b0;
        if (S_AR_VALID[i] && S_AR_READY[i]) ar_todo[i] = 1'b0;
        if (S_R_VALID[i] && S_R_READY[i])   r_act[i]   = 1'b0;
      end

      // Arbitration at this edge, from an idle path
      if (w_was_idle && |S_AW_VALID) begin
        wexp = pick(S_AW_VALID, wptr);
        wbusy = 1'b1;
      end
      if (r_was_idle && |S_AR_VALID) begin
        rexp = pick(S_AR_VALID, rptr);
        rbusy = 1'b1;
      end

      // New requests and timers for next cycle
      for (int i = 0; i < N; i++) begin
        if (aw_wait[i] > 0) aw_wait[i]--;
        if (w_wait[i] > 0)  w_wait[i]--;
        if (ar_wait[i] > 0) ar_wait[i]--;
        if (!w_act[i] && ($urandom % 4 == 0)) begin
          w_act[i] = 1; aw_todo[i] = 1; w_todo[i] = 1;
          aw_wait[i] = $urandom % 5; w_wait[i] = $urandom % 5;
          m_aw_addr[i] = $urandom; m_w_data[i] = $urandom; m_w_strb[i] = SW'($urandom);
        end
        if (!r_act[i] && ($urandom % 4 == 0)) begin
          r_act[i] = 1; ar_todo[i] = 1;
          ar_wait[i] = $urandom % 3; m_ar_addr[i] = $urandom;
        end
      end
      if (s_aw_have && s_w_have && !s_b_v) begin
        if (s_b_wait == 0) begin s_b_v = 1; s_b_resp = 2'($urandom); end
        else s_b_wait--;
      end
      if (s_ar_have && !s_r_v) begin
        if (s_r_wait == 0) begin s_r_v = 1; s_r_resp = 2'($urandom); s_r_data = $urandom; end
        else s_r_wait--;
      end
    end

    chk("wr_progress", 256'(nwr > 40), 256'(1));
    chk("rd_progress", 256'(nrd > 40), 256'(1));
    chk("reset_hit", 256'(did_rst), 256'(1));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
